// File: rtl/if_fetch_32.sv
// rtl/if_fetch_32.sv - instruction fetch stage: PC, imem req/ack handshake, next-PC selection, halt
// Optional feature macro: JR_ALIGN_CHECK_EN (halt on misaligned jr target instead of masking it)
module if_fetch_32 #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  branch,
  input  logic [1:0]  jump,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic        err_illegal_opcode,
  input  logic        exec_done,
  output logic        halted,
  output logic        err_fetch_timeout,
  output logic        err_misaligned
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_instr;
  logic [31:0]   w_instr_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_err_to;
  logic          w_err_to_nxt;

  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_br_offset;
  logic [31:0]   w_j_target;
  logic [31:0]   w_jr_target;
  logic [31:0]   w_next_pc;
  logic          w_br_taken;
  logic          w_misaligned;
  logic          w_stop;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_j_target  = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
  assign w_br_taken  = ((branch == 2'b10) && alu_zero) || ((branch == 2'b11) && !alu_zero);
  assign w_cnt_inc   = r_cnt + 1'b1;

`ifdef JR_ALIGN_CHECK_EN
  assign w_jr_target  = rs_data;
  assign w_misaligned = (jump == 2'b10) && (rs_data[1:0] != 2'b00);
`else
  // Low target bits are dropped so a jr always lands on a word boundary.
  assign w_jr_target  = rs_data & 32'hFFFF_FFFC;
  assign w_misaligned = 1'b0;
`endif

  assign w_stop = err_illegal_opcode || (jump == 2'b11) || w_misaligned;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump == 2'b10) begin
      w_next_pc = w_jr_target;
    end else if (jump == 2'b01) begin
      w_next_pc = w_j_target;
    end else if (w_br_taken) begin
      w_next_pc = w_pc_plus4 + w_br_offset;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_cnt_nxt    = r_cnt;
    w_err_to_nxt = r_err_to;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // An ack arriving on the limit cycle still counts as a good fetch.
        if (imem_ack) begin
          w_instr_nxt = imem_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ISSUE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(IMEM_TIMEOUT)) begin
            w_err_to_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end
        end
      end
      S_ISSUE: begin
        if (exec_done) begin
          if (w_stop) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt    = w_next_pc;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= 32'd0;
      r_cnt    <= '0;
      r_err_to <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err_to <= w_err_to_nxt;
    end
  end

`ifdef JR_ALIGN_CHECK_EN
  logic r_err_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_mis <= 1'b0;
    end else if ((r_state == S_ISSUE) && exec_done && w_misaligned) begin
      r_err_mis <= 1'b1;
    end
  end

  assign err_misaligned = r_err_mis;
`else
  assign err_misaligned = 1'b0;
`endif

  assign imem_req          = (r_state == S_FETCH);
  assign imem_addr         = r_pc;
  assign instr             = r_instr;
  assign instr_valid       = (r_state == S_ISSUE);
  assign opcode            = r_instr[31:26];
  assign funct             = r_instr[5:0];
  assign pc                = r_pc;
  assign pc_plus4          = w_pc_plus4;
  assign halted            = (r_state == S_HALT);
  assign err_fetch_timeout = r_err_to;

endmodule

// File: tb/tb_if_fetch_32.sv
// tb/tb_if_fetch_32.sv - self-checking bench for if_fetch_32 with a behavioural next-PC model
module tb_if_fetch_32;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic [31:0] rdata;
  logic [1:0]  br;
  logic [1:0]  jp;
  logic        zero;
  logic [31:0] rs;
  logic        ill;
  logic        done;

  logic        req, iv, hlt, eto, emis;
  logic [31:0] addr, ins, pcv, p4;
  logic [5:0]  opc, fn;

  logic        w_req, w_iv, w_hlt, w_eto, w_emis;
  logic [31:0] w_addr, w_ins, w_pcv, w_p4;
  logic [5:0]  w_opc, w_fn;

  int          n_checks;
  int          n_errors;
  logic [31:0] mpc;
  logic [31:0] minstr;
  bit          mhalted;

  always #5 clk = ~clk;

  if_fetch_32 #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .instr(ins), .instr_valid(iv), .opcode(opc), .funct(fn),
    .pc(pcv), .pc_plus4(p4),
    .branch(br), .jump(jp), .alu_zero(zero), .rs_data(rs),
    .err_illegal_opcode(ill), .exec_done(done),
    .halted(hlt), .err_fetch_timeout(eto), .err_misaligned(emis)
  );

  // Second instance shares every input; it runs in lockstep and is only inspected for PC wrap.
  if_fetch_32 #(.RESET_PC(WRAP_PC), .IMEM_TIMEOUT(16)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(ack), .imem_rdata(rdata),
    .instr(w_ins), .instr_valid(w_iv), .opcode(w_opc), .funct(w_fn),
    .pc(w_pcv), .pc_plus4(w_p4),
    .branch(br), .jump(jp), .alu_zero(zero), .rs_data(rs),
    .err_illegal_opcode(ill), .exec_done(done),
    .halted(w_hlt), .err_fetch_timeout(w_eto), .err_misaligned(w_emis)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; rdata = '0; br = '0; jp = '0;
    zero = 1'b0; rs = '0; ill = 1'b0; done = 1'b0;
    tick();
    expect_eq("rst_pc", pcv, 32'h0);
    expect_eq("rst_req", req, 1'b0);
    expect_eq("rst_iv", iv, 1'b0);
    expect_eq("rst_halted", hlt, 1'b0);
    expect_eq("rst_instr", ins, 32'h0);
    expect_eq("rst_eto", eto, 1'b0);
    expect_eq("rst_emis", emis, 1'b0);
    rst = 1'b0;
    mpc = 32'h0;
    mhalted = 1'b0;
    tick();
    expect_eq("idle_to_fetch_req", req, 1'b1);
  endtask

  task automatic fetch(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) begin
      expect_eq("fetch_req", req, 1'b1);
      expect_eq("fetch_addr", addr, mpc);
      expect_eq("fetch_iv", iv, 1'b0);
      ack = 1'b0;
      tick();
    end
    expect_eq("fetch_addr", addr, mpc);
    ack = 1'b1;
    rdata = word;
    tick();
    ack = 1'b0;
    rdata = $urandom;
    minstr = word;
    expect_eq("issue_iv", iv, 1'b1);
    expect_eq("issue_req", req, 1'b0);
    expect_eq("issue_instr", ins, word);
    expect_eq("issue_opcode", opc, word[31:26]);
    expect_eq("issue_funct", fn, word[5:0]);
    expect_eq("issue_pc_plus4", p4, mpc + 32'd4);
  endtask

  task automatic execute(input logic [1:0] br_i, input logic [1:0] jp_i, input logic zero_i,
                         input logic [31:0] rs_i, input logic ill_i, input int wait_n);
    logic [31:0] nxt;
    logic [31:0] pp4;
    int          off;
    bit          stop;
    bit          mis;
    for (int i = 0; i < wait_n; i++) begin
      done = 1'b0;
      ack = 1'(($urandom));
      rdata = $urandom;
      tick();
      expect_eq("wait_iv", iv, 1'b1);
      expect_eq("wait_pc", pcv, mpc);
      expect_eq("wait_instr", ins, minstr);
    end
    ack = 1'b0;
    br = br_i; jp = jp_i; zero = zero_i; rs = rs_i; ill = ill_i; done = 1'b1;

    pp4  = mpc + 32'd4;
    stop = ill_i || (jp_i == 2'b11);
    mis  = 1'b0;
    if (jp_i == 2'b10) begin
`ifdef JR_ALIGN_CHECK_EN
      if (rs_i % 4 != 0) begin
        stop = 1'b1;
        mis  = 1'b1;
      end
      nxt = rs_i;
`else
      nxt = rs_i - (rs_i % 4);
`endif
    end else if (jp_i == 2'b01) begin
      nxt = pp4 - (pp4 % 32'h1000_0000) + (minstr % 32'h0400_0000) * 4;
    end else if ((br_i == 2'b10 && zero_i) || (br_i == 2'b11 && !zero_i)) begin
      off = int'(minstr % 32'h0001_0000);
      if (off >= 32768) off = off - 65536;
      nxt = pp4 + off * 4;
    end else begin
      nxt = pp4;
    end

    tick();
    done = 1'b0; ill = 1'b0; jp = '0; br = '0;
    if (stop) begin
      mhalted = 1'b1;
      expect_eq("halt_halted", hlt, 1'b1);
      expect_eq("halt_pc", pcv, mpc);
      expect_eq("halt_req", req, 1'b0);
      expect_eq("halt_iv", iv, 1'b0);
      expect_eq("halt_emis", emis, mis);
    end else begin
      mpc = nxt;
      expect_eq("next_pc", pcv, mpc);
      expect_eq("next_addr", addr, mpc);
      expect_eq("next_req", req, 1'b1);
      expect_eq("next_iv", iv, 1'b0);
      expect_eq("next_halted", hlt, 1'b0);
    end
  endtask

  task automatic halt_ignore(input int n);
    for (int i = 0; i < n; i++) begin
      ack = 1'b1; done = 1'b1; rdata = $urandom;
      tick();
      expect_eq("halted_sticky", hlt, 1'b1);
      expect_eq("halted_req", req, 1'b0);
      expect_eq("halted_iv", iv, 1'b0);
      expect_eq("halted_pc", pcv, mpc);
    end
    ack = 1'b0; done = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    fetch(0, 32'h0800_0000 | (target >> 2));
    execute(2'b00, 2'b01, 1'b0, 32'h0, 1'b0, 0);
  endtask

  initial begin
    logic [31:0] w;
    int          r;
    n_checks = 0;
    n_errors = 0;
    mhalted  = 1'b0;

    do_reset();
    fetch(2, 32'h2008_0005);
    expect_eq("basic_opcode", opc, 32'(6'b001000));
    execute(2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1);
    expect_eq("basic_next_addr", addr, 32'h4);

    goto_pc(32'h10);
    fetch(1, 32'h1000_FFFF);
    execute(2'b10, 2'b00, 1'b1, 32'h0, 1'b0, 0);
    expect_eq("beq_taken", pcv, 32'h10);
    fetch(0, 32'h1000_FFFF);
    execute(2'b10, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    expect_eq("beq_not_taken", pcv, 32'h14);
    goto_pc(32'h10);
    fetch(0, 32'h1000_FFFF);
    execute(2'b11, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    expect_eq("bne_taken", pcv, 32'h10);

    goto_pc(32'h40);
    fetch(0, 32'h0800_0100);
    execute(2'b00, 2'b01, 1'b0, 32'h0, 1'b0, 0);
    expect_eq("j_target", pcv, 32'h400);
    fetch(0, 32'h0000_0008);
    execute(2'b00, 2'b10, 1'b0, 32'h0000_0100, 1'b0, 0);
    expect_eq("jr_target", pcv, 32'h100);
    fetch(0, 32'h0000_0008);
    execute(2'b00, 2'b10, 1'b0, 32'h0000_0102, 1'b0, 0);
`ifdef JR_ALIGN_CHECK_EN
    expect_eq("jr_mis_halted", hlt, 1'b1);
    expect_eq("jr_mis_err", emis, 1'b1);
    expect_eq("jr_mis_pc", pcv, 32'h100);
`else
    expect_eq("jr_mask_pc", pcv, 32'h100);
    expect_eq("jr_mask_err", emis, 1'b0);
`endif

    do_reset();
    ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      expect_eq("timeout_not_yet", hlt, 1'b0);
    end
    tick();
    expect_eq("timeout_halted", hlt, 1'b1);
    expect_eq("timeout_err", eto, 1'b1);
    expect_eq("timeout_req", req, 1'b0);
    halt_ignore(2);

    do_reset();
    fetch(15, 32'h0000_0020);
    expect_eq("ack_at_limit_err", eto, 1'b0);
    expect_eq("ack_at_limit_halted", hlt, 1'b0);
    execute(2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);

    fetch(1, 32'hFC00_0000);
    execute(2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 0);
    expect_eq("illegal_halted", hlt, 1'b1);
    halt_ignore(4);
    do_reset();

    fetch(0, 32'h0000_0020);
    execute(2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    expect_eq("pre_async_req", req, 1'b1);
    #2 rst = 1'b1;
    #1;
    expect_eq("async_rst_req", req, 1'b0);
    expect_eq("async_rst_pc", pcv, 32'h0);
    do_reset();

    expect_eq("wrap_reset_addr", w_addr, WRAP_PC);
    expect_eq("wrap_pc_plus4", w_p4, 32'h0);
    fetch(1, 32'h0000_0020);
    execute(2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    expect_eq("wrap_next_addr", w_addr, 32'h0);
    expect_eq("wrap_next_req", w_req, 1'b1);

    for (int k = 0; k < 60; k++) begin
      w = $urandom;
      fetch($urandom_range(0, 4), w);
      r = $urandom_range(0, 19);
      execute(2'($urandom_range(0, 3)),
              (r < 2) ? 2'b11 : 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)),
              $urandom,
              (r == 2),
              $urandom_range(0, 2));
      if (mhalted) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_32.md
Name: if_fetch_32

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and fetches words from instruction memory over a req/ack handshake.
- Presents the instruction and its opcode/funct fields to the decoder, then consumes the decoder's branch/jump encodings, the ALU zero flag and rs data to compute the next PC.
- Halts on an illegal opcode, an invalid jump encoding or a fetch timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_TIMEOUT, 16, FETCH cycles without imem_ack before a timeout halt (minimum 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  instruction word valid on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr/opcode/funct are valid for decode.
- opcode  out  6  instr[31:26], to the decoder.
- funct  out  6  instr[5:0], to the decoder.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, the link value for jal.
- branch  in  2  00 off, 10 beq, 11 bne.
- jump  in  2  00 none, 01 j/jal, 10 jr, 11 invalid.
- alu_zero  in  1  ALU zero flag.
- rs_data  in  32  register rs value, used as the jr target.
- err_illegal_opcode  in  1  decoder illegal-opcode flag.
- exec_done  in  1  downstream has consumed the current instruction.
- halted  out  1  core stopped; sticky until rst.
- err_fetch_timeout  out  1  sticky; set when a fetch times out.
- err_misaligned  out  1  sticky; set on a misaligned jr target (optional feature).

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE, timeout counter=0, instr=0.
  - imem_req, instr_valid, halted and all err_* outputs = 0.
- States:
  - IDLE -> FETCH unconditionally on the next edge.
  - FETCH:
    - imem_req=1 and imem_addr=pc, both stable.
    - If imem_ack=1: instr<=imem_rdata, counter<=0, go to ISSUE. instr_valid rises the cycle after ack (latency 1).
    - If imem_ack=0: counter increments. When the counter would reach IMEM_TIMEOUT: go to HALT with err_fetch_timeout=1.
    - Ack in the same cycle as the counter limit: ack wins.
  - ISSUE:
    - imem_req=0, instr_valid=1. Wait for exec_done.
    - On exec_done=1, if err_illegal_opcode=1 or jump=11: go to HALT with pc unchanged.
    - Otherwise pc<=next_pc, instr_valid<=0, go to FETCH.
  - HALT:
    - halted=1, imem_req=0, instr_valid=0.
    - Leaves only via rst.
- imem_ack outside FETCH is ignored. exec_done outside ISSUE is ignored.
- next_pc priority, highest first:
  - jump=10: rs_data.
  - jump=01: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch=10 with alu_zero=1, or branch=11 with alu_zero=0: pc_plus4 + (sign-extended instr[15:0] << 2).
  - Otherwise: pc_plus4.
- Arithmetic: all 32-bit, modulo 2^32; the PC wraps silently. No delay slot.
- opcode, funct and pc_plus4 are combinational from the registered instr and pc.

Optional Feature:
- Macro: JR_ALIGN_CHECK_EN.
- Defined: on a jr target with rs_data[1:0]!=0 at exec_done, go to HALT with err_misaligned=1 and pc unchanged.
- Undefined: the jr target is {rs_data[31:2], 2'b00}, and err_misaligned is tied to 0.

Test Plan:
- Basic fetch: reset with RESET_PC=0, ack 0x20080005 two cycles after imem_req -> instr_valid=1 the cycle after ack, opcode=6'b001000. Then exec_done with branch=00, jump=00 -> imem_addr=0x4.
- Branch, pc=0x10, instr 0x1000FFFF:
  - branch=10, zero=1 -> next pc 0x10.
  - zero=0 -> 0x14.
  - branch=11, zero=0 -> 0x10.
- Jumps:
  - pc=0x40, instr 0x08000100, jump=01 -> next pc 0x400.
  - jump=10, rs_data=0x0000_0100 -> 0x100.
  - rs_data=0x102 -> with macro: halted=1, err_misaligned=1, pc unchanged; without: next pc 0x100.
- Timeout, IMEM_TIMEOUT=16:
  - no ack for 16 cycles -> halted=1, err_fetch_timeout=1, imem_req=0.
  - separate run, ack on the 16th cycle -> accepted, no error.
- Illegal opcode: err_illegal_opcode=1 with exec_done -> halted=1, pc unchanged, further ack/exec_done ignored. rst -> pc=RESET_PC, halted=0.
- Wrap and reset mid-fetch:
  - RESET_PC=0xFFFF_FFFC, plain instruction -> next imem_addr 0x0000_0000.
  - rst asserted in FETCH -> imem_req=0 in the same cycle, asynchronously.
